rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one resource among eight requesters. Each cycle it grants one requester and presents the grant as a 3-bit index plus the matching one-hot line. Internally the one-hot line comes from a 3-to-8 decode of the registered index. The arbiter sits between the requester array and the shared resource. Its one-hot grant drives the resource's per-requester select/enable lines directly.

## Interface
- `NUM_REQ`, 8: number of requesters; fixed at 8 because the grant decode is 3-to-8.
- `IDX_W`, 3: width of the grant index.
- `MAX_HOLD`, 16: maximum number of cycles one grant may be held. Used only when the timeout feature is compiled in; legal range 2..255.
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `req`, input, 8: request lines; bit k is requester k. A requester holds its bit high for the whole time it owns the resource.
- `gnt`, output, 8: one-hot grant; all-zero when idle.
- `gnt_idx`, output, 3: index of the current owner; valid only while `gnt_valid` is 1.
- `gnt_valid`, output, 1: high while a grant is active.
- `timeout`, output, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: exactly one requester owns the resource.
- IDLE → GRANT:
  - Taken when `req` is non-zero at a rising edge.
  - Winner is the first set bit found by searching upward from `last_idx + 1`, wrapping 7 → 0.
  - `last_idx` is the previous winner.
- GRANT → IDLE:
  - Taken when `req[gnt_idx]` is sampled low; the owner has released.
  - Requests from other requesters are ignored while in GRANT; there is no preemption.
- On every new grant, `last_idx` takes the winner's index. The former owner therefore becomes lowest priority for the next arbitration.
- `gnt` is the 3-to-8 decode of `gnt_idx`, gated by `gnt_valid`. It is never anything other than one-hot or zero.
- Requests that drop before being granted are forgotten; no request is latched.
- Requester whose request is high on the release edge:
  - The former owner loses the grant at that edge like any other release.
  - It is re-granted two cycles later only if no other requester wins the round-robin search.

## Timing
- Reset values: state IDLE, `gnt` = 0, `gnt_idx` = 0, `gnt_valid` = 0, `timeout` = 0, `last_idx` = 7, so the first search starts at requester 0.
- Grant latency: `req` high in cycle t gives `gnt` high in cycle t+1. All outputs are registered.
- Release latency:
  - Owner drops `req` in cycle t; `gnt` goes to 0 in cycle t+1.
  - The earliest next grant appears in cycle t+2.
  - This guaranteed one-cycle gap is the resource's turnaround cycle.
- Simultaneous requests are resolved only by the round-robin order. With every `req` bit high and each owner releasing after one cycle, grants proceed 0, 1, 2, … 7, 0 with one idle cycle between grants.
- Reset asserted mid-grant:
  - `gnt` clears immediately, asynchronously.
  - The pointer returns to 7.
  - The first grant after reset release follows the normal one-cycle latency.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on entry to GRANT and increments every cycle in GRANT.
  - When it reaches `MAX_HOLD` − 1 while the owner still requests, the next edge forces IDLE and drives `timeout` high for that one cycle.
  - `last_idx` is already that owner, so it loses priority.
  - A normal release on the same edge as the limit takes precedence: no `timeout` pulse.
- Undefined:
  - No counter is built; `timeout` is tied to 0.
  - Grants are held indefinitely.

## Structure
- Package `rr_arb_pkg` holds `NUM_REQ`, `IDX_W`, and the two-value state enum (IDLE, GRANT).
- One sub-module, `onehot_dec3to8`: a purely combinational index-to-one-hot decoder with an enable. It produces `gnt` from `gnt_idx` and `gnt_valid`.
- The round-robin search is a priority scan of `req` rotated by `last_idx + 1`, kept inside the top module.

## Test plan
- Reset, then `req` = 8'b0000_0000 for 5 cycles → `gnt` = 0, `gnt_valid` = 0 throughout.
- Single requester: `req` = 8'b0000_1000 from cycle 2, dropped in cycle 6 → `gnt` = 8'b0000_1000 and `gnt_idx` = 3 in cycles 3–6; `gnt` = 0 from cycle 7.
- `req` = 8'hFF, each owner releasing one cycle after its grant → grant order 0, 1, …, 7, 0; every grant is followed by an idle cycle; `gnt` is never multi-hot.
- Owner 2 holds while `req` = 8'b1000_0100, then releases → next grant goes to 7, not 2, even though bit 2 rises again on the release edge.
- Reset asserted in the middle of a grant to requester 5 → `gnt` = 0 with no clock edge needed; after release of reset with `req` = 8'b0010_0001, the first grant goes to 0.
- With `RR_ARB_TIMEOUT_EN` and `MAX_HOLD` = 4:
  - Requester 1 holds `req` indefinitely → grant lasts 4 cycles, `timeout` pulses for 1 cycle, then requester 1 is re-granted if it is the only requester.
  - Without the macro → the grant never ends and `timeout` stays 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/onehot_dec3to8.sv
// Combinational 3-to-8 index decoder with enable; output is one-hot or all-zero.
module onehot_dec3to8 (
    input  logic [2:0] idx,
    input  logic       en,
    output logic [7:0] onehot
);

    // Decode the index only while enabled so the output can never be multi-hot.
    always_comb begin
        onehot = 8'b0000_0000;
        if (en) begin
            onehot = 8'b0000_0001 << idx;
        end else begin
            onehot = 8'b0000_0000;
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with registered index/valid and decoded one-hot grant.
// Optional hold-time limit with forced revocation is compiled in by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    arb_state_e       state_r;
    arb_state_e       state_nx_s;
    logic [IDX_W-1:0] gnt_idx_r;
    logic [IDX_W-1:0] gnt_idx_nx_s;
    logic             gnt_valid_r;
    logic [IDX_W-1:0] last_idx_r;
    logic [IDX_W-1:0] last_idx_nx_s;
    logic             timeout_r;
    logic             timeout_nx_s;
    logic [IDX_W-1:0] start_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_found_s;

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt_r;
    logic [7:0] hold_cnt_nx_s;
`endif

    // Rotated priority scan: the first set bit at or above last_idx+1 wins, wrapping 7 -> 0.
    always_comb begin
        start_s     = last_idx_r + 3'd1;
        win_idx_s   = 3'd0;
        win_found_s = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[start_s + IDX_W'(i)]) begin
                win_idx_s   = start_s + IDX_W'(i);
                win_found_s = 1'b1;
            end else begin
                win_idx_s   = win_idx_s;
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-output logic; release always wins over the hold limit.
    always_comb begin
        state_nx_s    = state_r;
        gnt_idx_nx_s  = gnt_idx_r;
        last_idx_nx_s = last_idx_r;
        timeout_nx_s  = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        hold_cnt_nx_s = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    state_nx_s    = GRANT;
                    gnt_idx_nx_s  = win_idx_s;
                    last_idx_nx_s = win_idx_s;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_cnt_nx_s = 8'd0;
`endif
                end else begin
                    state_nx_s = IDLE;
                end
            end
            GRANT: begin
                if (!req[gnt_idx_r]) begin
                    state_nx_s = IDLE;
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (hold_cnt_r == HOLD_LIM) begin
                    state_nx_s   = IDLE;
                    timeout_nx_s = 1'b1;
                end else begin
                    state_nx_s    = GRANT;
                    hold_cnt_nx_s = hold_cnt_r + 8'd1;
                end
`else
                else begin
                    state_nx_s = GRANT;
                end
`endif
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State and output registers; the pointer resets to 7 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
            last_idx_r  <= 3'd7;
            timeout_r   <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            gnt_idx_r   <= gnt_idx_nx_s;
            gnt_valid_r <= (state_nx_s == GRANT);
            last_idx_r  <= last_idx_nx_s;
            timeout_r   <= timeout_nx_s;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter: cycles spent in the current grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else begin
            hold_cnt_r <= hold_cnt_nx_s;
        end
    end
`endif

    onehot_dec3to8 u_dec (
        .idx    (gnt_idx_r),
        .en     (gnt_valid_r),
        .onehot (gnt)
    );

    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus randomized traffic against a behavioural model.
module tb_rr_arbiter8;

    localparam int TB_MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req   = 8'd0;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Behavioural model: who owns the resource, who won last, how long the grant has been visible.
    bit m_valid = 1'b0;
    int m_idx   = 0;
    int m_last  = 7;
    int m_held  = 0;
    bit m_to    = 1'b0;

    function automatic int rr_pick(input logic [7:0] r, input int last);
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_last  <= 7;
            m_held  <= 0;
            m_to    <= 1'b0;
        end else begin
            m_to <= 1'b0;
            if (!m_valid) begin
                if (req != 8'd0) begin
                    m_valid <= 1'b1;
                    m_idx   <= rr_pick(req, m_last);
                    m_last  <= rr_pick(req, m_last);
                    m_held  <= 1;
                end
            end else if (!req[m_idx]) begin
                m_valid <= 1'b0;
            end else if (TO_EN && m_held == TB_MAX_HOLD) begin
                m_valid <= 1'b0;
                m_to    <= 1'b1;
            end else begin
                m_held <= m_held + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [7:0] exp_gnt;

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_gnt = m_valid ? (8'd1 << m_idx) : 8'd0;
            chk("model_gnt", {24'd0, gnt}, {24'd0, exp_gnt});
            chk("model_valid", {31'd0, gnt_valid}, {31'd0, m_valid});
            chk("model_timeout", {31'd0, timeout}, {31'd0, m_to});
            if (m_valid) chk("model_idx", {29'd0, gnt_idx}, {29'd0, m_idx[2:0]});
            chk("onehot", {31'd0, ($countones(gnt) <= 1)}, 32'd1);
        end
    end

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'd0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] r;

    initial begin
        do_reset();
        chk_en = 1'b1;
        chk("rst_gnt", {24'd0, gnt}, 32'd0);
        chk("rst_idx", {29'd0, gnt_idx}, 32'd0);
        chk("rst_valid", {31'd0, gnt_valid}, 32'd0);
        chk("rst_timeout", {31'd0, timeout}, 32'd0);

        // Idle requests.
        for (int i = 0; i < 5; i++) begin
            step(8'h00);
            chk("idle_gnt", {24'd0, gnt}, 32'd0);
        end

        // Single requester 3.
        for (int i = 0; i < 4; i++) begin
            step(8'h08);
            chk("single_gnt", {24'd0, gnt}, 32'h08);
            chk("single_idx", {29'd0, gnt_idx}, 32'd3);
        end
        step(8'h00);
        chk("single_release", {24'd0, gnt}, 32'd0);
        step(8'h00);

        // All requesting, each owner releasing one cycle after its grant.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF);
            chk("ff_idx", {29'd0, gnt_idx}, 32'(k % 8));
            chk("ff_valid", {31'd0, gnt_valid}, 32'd1);
            r = 8'hFF;
            r[k % 8] = 1'b0;
            step(r);
            chk("ff_gap", {31'd0, gnt_valid}, 32'd0);
        end

        // Owner 2 holds, releases, re-requests on the following edge: 7 must win.
        do_reset();
        step(8'h04);
        chk("own2_idx", {29'd0, gnt_idx}, 32'd2);
        for (int i = 0; i < 3; i++) step(8'h84);
        chk("own2_hold", {24'd0, gnt}, 32'h04);
        step(8'h80);
        chk("own2_rel", {31'd0, gnt_valid}, 32'd0);
        step(8'h84);
        chk("own2_next", {24'd0, gnt}, 32'h80);
        step(8'h00);

        // Asynchronous reset in the middle of a grant to 5.
        do_reset();
        step(8'h20);
        chk("async_pre", {24'd0, gnt}, 32'h20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr", {24'd0, gnt}, 32'd0);
        req = 8'h21;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("async_first", {24'd0, gnt}, 32'h01);
        chk("async_first_idx", {29'd0, gnt_idx}, 32'd0);

        // Hold limit behaviour.
        do_reset();
`ifdef RR_ARB_TIMEOUT_EN
        for (int i = 0; i < TB_MAX_HOLD; i++) begin
            step(8'h02);
            chk("to_hold", {24'd0, gnt}, 32'h02);
            chk("to_quiet", {31'd0, timeout}, 32'd0);
        end
        step(8'h02);
        chk("to_pulse", {31'd0, timeout}, 32'd1);
        chk("to_revoked", {31'd0, gnt_valid}, 32'd0);
        step(8'h02);
        chk("to_regrant", {24'd0, gnt}, 32'h02);
        chk("to_pulse_end", {31'd0, timeout}, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            step(8'h02);
            chk("nto_hold", {24'd0, gnt}, 32'h02);
            chk("nto_timeout", {31'd0, timeout}, 32'd0);
        end
`endif

        // Randomized traffic; owners usually keep requesting.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = 8'($urandom);
            if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
            if (m_valid && $urandom_range(0, 3) != 0) r[m_idx] = 1'b1;
            step(r);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
